fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
- Parametrised successor to the spectrum front end.
- Arms on a start pulse and captures one frame of 2^LOG2N time samples, synchronised to a level-crossing trigger, into an internal buffer.
- Streams the frame to an external FFT core over AXI-Stream, then receives the complex spectrum back.
- Emits a gain-scaled, saturated power byte per bin with bin address; optional two-frame running average and continuous re-arm.

Parameters:
- LOG2N, 10, log2 of frame length N.
- SAMPLE_W, 8, signed time-sample width.
- FFT_W, 19, significant signed bits per real/imag lane of FFT output.
- LANE_W, 24, width of each lane in s_axis_tdata.
- OUT_W, 8, output power width.
- BASE_SHIFT, 23, right shift applied at gain=0.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle arm request.
- cont  in  1  1 = re-arm automatically after each frame.
- trig_mode  in  2  0 free-run, 1 rising crossing, 2 falling crossing, 3 reserved (treated as 0).
- trig_level  in  SAMPLE_W  signed crossing threshold.
- gain  in  3  output gain select.
- avg_en  in  1  enable two-frame averaging.
- smp_valid  in  1  time sample strobe.
- smp_data  in  SAMPLE_W  signed time sample.
- m_axis_tdata  out  2*SAMPLE_W  {imag=0, real=sample}.
- m_axis_tvalid  out  1; m_axis_tready  in  1; m_axis_tlast  out  1.
- s_axis_tdata  in  2*LANE_W  {imag lane, real lane}.
- s_axis_tvalid  in  1; s_axis_tready  out  1; s_axis_tlast  in  1.
- freq_valid  out  1  output bin strobe.
- freq_addr  out  LOG2N  bin index.
- freq_data  out  OUT_W  scaled power.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after last bin written.
- err_tlast  out  1  one-cycle pulse on tlast mismatch.

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; prev-sample register 0; avg-first flag set. Average RAM contents undefined after reset. Reset mid-frame aborts immediately; no partial output follows.
- FSM states: IDLE, ARM, CAPTURE, LOAD, UNLOAD.
- IDLE: start=1 -> ARM. start in any other state is ignored.
- ARM: each smp_valid updates prev. Trigger fires on a valid sample when:
  - mode 1: prev<trig_level and smp_data>=trig_level;
  - mode 2: prev>=trig_level and smp_data<trig_level;
  - modes 0/3: the first valid sample.
  The trigger sample is written as buffer[0] and the FSM goes to CAPTURE. The first valid sample after entering ARM only loads prev; it never triggers in modes 1/2.
- CAPTURE: each valid sample writes buffer[wr_cnt], wr_cnt++. After buffer[N-1] is written -> LOAD. Samples arriving outside ARM/CAPTURE are dropped.
- LOAD:
  - m_axis_tvalid=1; data = buffer[rd_cnt] sign-kept in the low SAMPLE_W bits, high SAMPLE_W bits zero; m_axis_tlast=1 only when rd_cnt=N-1.
  - Data, tlast and valid are held stable while tready=0; rd_cnt advances only on tvalid&tready.
  - Buffer read is registered: present the next word in advance so no bubble occurs when tready stays high.
  - After the N-1 beat is accepted -> UNLOAD.
- UNLOAD:
  - s_axis_tready=1; beat counter bin advances on each accepted beat.
  - Beat with tlast=1 and bin!=N-1: err_tlast pulse; frame ends after that beat.
  - Beat at bin=N-1 with tlast=0: err_tlast pulse; frame still ends.
  - Frame end -> ARM if cont=1, else IDLE.
- Power pipeline, 2 cycles after the accepted beat:
  - Stage 1: re = signed lane0[FFT_W-1:0], im = signed lane1[FFT_W-1:0]; p = re*re + im*im, unsigned, 2*FFT_W bits.
  - Stage 2: s = p >> (BASE_SHIFT - gain); v = s saturated to 2^OUT_W-1 if any bit above OUT_W-1 is set.
  - Averaging: if avg_en=1 and avg-first=0, out = (avg_ram[bin] + v + 1) >> 1, computed OUT_W+1 wide; otherwise out = v. avg_ram[bin] <= out.
  - freq_valid/freq_addr/freq_data are registered together.
- frame_done pulses one cycle after the final freq_valid. avg-first clears at frame_done and sets whenever avg_en=0.
- The pipeline drains fully even if the FSM has already left UNLOAD.

Test Plan (bench LOG2N=4, N=16):
- Free-run: mode 0, start, 16 ramp samples 0..15 with tready=1 -> 16 m_axis beats with data 0..15, tlast only on beat 15, no gaps.
- Rising trigger: level=0, samples -3,-1,2,5,... -> buffer[0]=2. A falling sequence never triggers; busy stays 1.
- Backpressure: toggle tready every cycle during LOAD -> tdata/tlast stable while stalled, 16 accepted beats in order.
- Scaling: bin beat re=1000, im=0, gain=7 -> p=1000000 >> 16 = 15 on freq_data at bin addr, 2 cycles later. re=2^18-1, gain=7 -> 255 (saturated).
- Averaging: avg_en=1, two frames with the bin-3 value 100 then 50 -> frame 1 outputs 100, frame 2 outputs 75.
- Errors/reset: tlast on bin 5 -> err_tlast pulse, frame ends, cont=1 -> ARM. Deassert aresetn mid-LOAD -> next cycle busy=0 and m_axis_tvalid=0.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame controller between a sample stream and an external FFT core.
// It captures one triggered frame, streams it out, and turns the returned spectrum into scaled power bytes.
module fft_frame_ctrl #(
   parameter int LOG2N      = 10,
   parameter int SAMPLE_W   = 8,
   parameter int FFT_W      = 19,
   parameter int LANE_W     = 24,
   parameter int OUT_W      = 8,
   parameter int BASE_SHIFT = 23
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic                  cont,
   input  logic [1:0]            trig_mode,
   input  logic [SAMPLE_W-1:0]   trig_level,
   input  logic [2:0]            gain,
   input  logic                  avg_en,
   input  logic                  smp_valid,
   input  logic [SAMPLE_W-1:0]   smp_data,
   output logic [2*SAMPLE_W-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   input  logic [2*LANE_W-1:0]   s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic                  freq_valid,
   output logic [LOG2N-1:0]      freq_addr,
   output logic [OUT_W-1:0]      freq_data,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err_tlast
);

   localparam int N  = 1 << LOG2N;
   localparam int PW = 2 * FFT_W;
   localparam logic [LOG2N-1:0] LAST_IDX = '1;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARM     = 3'd1;
   localparam logic [2:0] CAPTURE = 3'd2;
   localparam logic [2:0] LOAD    = 3'd3;
   localparam logic [2:0] UNLOAD  = 3'd4;

   logic [2:0]                  stateReg, stateNext;
   logic [LOG2N-1:0]            wrCntReg, wrCntNext;
   logic [LOG2N-1:0]            rdCntReg, rdCntNext;
   logic [LOG2N-1:0]            binReg, binNext;
   logic signed [SAMPLE_W-1:0]  prevReg, prevNext;
   logic                        havePrevReg, havePrevNext;

   logic [SAMPLE_W-1:0]         frameBuf [N];
   logic [SAMPLE_W-1:0]         rdDataReg;
   logic                        bufWe, bufRe;
   logic [LOG2N-1:0]            bufWrAddr, bufRdAddr;

   logic signed [SAMPLE_W-1:0]  smpS, levelS;
   logic                        trigHit;
   logic                        mAccept, sAccept, binIsLast, frameEnd;
   logic                        errReg;

   assign smpS   = smp_data;
   assign levelS = trig_level;

   // The first sample after arming only primes prevReg, so crossing modes need havePrevReg.
   always_comb begin
      case (trig_mode)
         2'd1:    trigHit = havePrevReg && (prevReg < levelS) && (smpS >= levelS);
         2'd2:    trigHit = havePrevReg && (prevReg >= levelS) && (smpS < levelS);
         default: trigHit = 1'b1;
      endcase
   end

   assign m_axis_tvalid = (stateReg == LOAD);
   assign m_axis_tlast  = (stateReg == LOAD) && (rdCntReg == LAST_IDX);
   assign m_axis_tdata  = {{SAMPLE_W{1'b0}}, rdDataReg};
   assign s_axis_tready = (stateReg == UNLOAD);
   assign busy          = (stateReg != IDLE);

   assign mAccept   = m_axis_tvalid & m_axis_tready;
   assign sAccept   = s_axis_tready & s_axis_tvalid;
   assign binIsLast = (binReg == LAST_IDX);
   assign frameEnd  = s_axis_tlast | binIsLast;

   always_comb begin
      stateNext    = stateReg;
      wrCntNext    = wrCntReg;
      rdCntNext    = rdCntReg;
      binNext      = binReg;
      prevNext     = prevReg;
      havePrevNext = havePrevReg;
      bufWe        = 1'b0;
      bufWrAddr    = wrCntReg;
      bufRe        = 1'b0;
      bufRdAddr    = rdCntReg + LOG2N'(1);
      case (stateReg)
         IDLE: begin
            if (start) begin
               stateNext    = ARM;
               havePrevNext = 1'b0;
            end
         end
         ARM: begin
            if (smp_valid) begin
               prevNext     = smpS;
               havePrevNext = 1'b1;
               if (trigHit) begin
                  bufWe     = 1'b1;
                  bufWrAddr = '0;
                  wrCntNext = LOG2N'(1);
                  stateNext = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (smp_valid) begin
               bufWe     = 1'b1;
               wrCntNext = wrCntReg + LOG2N'(1);
               if (wrCntReg == LAST_IDX) begin
                  // Prefetch word 0 now so the first LOAD cycle already has valid data.
                  stateNext = LOAD;
                  rdCntNext = '0;
                  bufRe     = 1'b1;
                  bufRdAddr = '0;
               end
            end
         end
         LOAD: begin
            if (mAccept) begin
               rdCntNext = rdCntReg + LOG2N'(1);
               bufRe     = 1'b1;
               if (rdCntReg == LAST_IDX) begin
                  stateNext = UNLOAD;
                  binNext   = '0;
               end
            end
         end
         UNLOAD: begin
            if (sAccept) begin
               binNext = binReg + LOG2N'(1);
               if (frameEnd) begin
                  stateNext    = cont ? ARM : IDLE;
                  havePrevNext = 1'b0;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         stateReg    <= IDLE;
         wrCntReg    <= '0;
         rdCntReg    <= '0;
         binReg      <= '0;
         prevReg     <= '0;
         havePrevReg <= 1'b0;
         errReg      <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         wrCntReg    <= wrCntNext;
         rdCntReg    <= rdCntNext;
         binReg      <= binNext;
         prevReg     <= prevNext;
         havePrevReg <= havePrevNext;
         errReg      <= sAccept & (s_axis_tlast ^ binIsLast);
      end
   end

   assign err_tlast = errReg;

   always_ff @(posedge aclk) begin
      if (bufWe) frameBuf[bufWrAddr] <= smp_data;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn)   rdDataReg <= '0;
      else if (bufRe) rdDataReg <= frameBuf[bufRdAddr];
   end

   // Only the low FFT_W bits of each lane are significant.
   logic [PW-1:0] laneSq [2];
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic signed [FFT_W-1:0] laneVal;
         logic signed [PW-1:0]    laneExt;
         assign laneVal   = s_axis_tdata[gi*LANE_W +: FFT_W];
         assign laneExt   = PW'(laneVal);
         assign laneSq[gi] = laneExt * laneExt;
      end
   endgenerate

   logic [PW-1:0]    powerSum;
   logic             s1ValidReg, s1LastReg;
   logic [LOG2N-1:0] s1BinReg;
   logic [PW-1:0]    s1PowerReg;
   logic [OUT_W-1:0] avgRam [N];
   logic [OUT_W-1:0] avgRdReg;

   assign powerSum = laneSq[0] + laneSq[1];

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         s1ValidReg <= 1'b0;
         s1LastReg  <= 1'b0;
         s1BinReg   <= '0;
         s1PowerReg <= '0;
      end else begin
         s1ValidReg <= sAccept;
         if (sAccept) begin
            s1LastReg  <= frameEnd;
            s1BinReg   <= binReg;
            s1PowerReg <= powerSum;
         end
      end
   end

   // Average RAM read is issued with the beat so its data lines up with stage 2.
   always_ff @(posedge aclk) begin
      if (sAccept) avgRdReg <= avgRam[binReg];
   end

   logic [7:0]       shAmt;
   logic [PW-1:0]    shifted;
   logic [OUT_W-1:0] satVal, avgVal, outVal;
   logic [OUT_W:0]   avgSum;
   logic             avgFirstReg;

   always_comb begin
      shAmt   = 8'(BASE_SHIFT) - {5'd0, gain};
      shifted = s1PowerReg >> shAmt;
      satVal  = (|shifted[PW-1:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
      avgSum  = {1'b0, avgRdReg} + {1'b0, satVal} + (OUT_W+1)'(1);
      avgVal  = avgSum[OUT_W:1];
      outVal  = (avg_en && !avgFirstReg) ? avgVal : satVal;
   end

   always_ff @(posedge aclk) begin
      if (s1ValidReg) avgRam[s1BinReg] <= outVal;
   end

   logic freqLastReg;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         freq_valid  <= 1'b0;
         freq_addr   <= '0;
         freq_data   <= '0;
         freqLastReg <= 1'b0;
         frame_done  <= 1'b0;
         avgFirstReg <= 1'b1;
      end else begin
         freq_valid  <= s1ValidReg;
         freqLastReg <= s1ValidReg & s1LastReg;
         frame_done  <= freqLastReg;
         if (s1ValidReg) begin
            freq_addr <= s1BinReg;
            freq_data <= outVal;
         end
         if (!avg_en)         avgFirstReg <= 1'b1;
         else if (frame_done) avgFirstReg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with N=16: the bench plays both the sample source and the FFT core.
module tb_fft_frame_ctrl;

   localparam int LOG2N = 4;
   localparam int N     = 16;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        start = 1'b0, cont = 1'b0;
   logic [1:0]  trig_mode = 2'd0;
   logic [7:0]  trig_level = 8'd0;
   logic [2:0]  gain = 3'd7;
   logic        avg_en = 1'b0;
   logic        smp_valid = 1'b0;
   logic [7:0]  smp_data = 8'd0;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast;
   logic        m_axis_tready = 1'b1;
   logic [47:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic        freq_valid;
   logic [3:0]  freq_addr;
   logic [7:0]  freq_data;
   logic        busy, frame_done, err_tlast;

   fft_frame_ctrl #(.LOG2N(LOG2N), .SAMPLE_W(8), .FFT_W(19), .LANE_W(24), .OUT_W(8), .BASE_SHIFT(23)) dut (
      .aclk(aclk), .aresetn(aresetn), .start(start), .cont(cont), .trig_mode(trig_mode),
      .trig_level(trig_level), .gain(gain), .avg_en(avg_en), .smp_valid(smp_valid), .smp_data(smp_data),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .freq_valid(freq_valid),
      .freq_addr(freq_addr), .freq_data(freq_data), .busy(busy), .frame_done(frame_done), .err_tlast(err_tlast)
   );

   always #5 aclk = ~aclk;

   int checks = 0, errors = 0;
   int cycCnt = 0, errPulses = 0, fdCount = 0;
   logic [8:0]  mExp [$];
   logic [15:0] fExp [$];
   logic [8:0]  mHead;
   logic [15:0] fHead;
   int acceptCyc [N];
   int smpArr [24];
   int beatRe [N], beatIm [N];
   int avgM [N];
   bit avgFirstM = 1'b1;

   task automatic checkVal(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] laneEnc(input int v, input logic [4:0] junk);
      logic [31:0] t;
      t = v;
      return {junk, t[18:0]};
   endfunction

   always @(posedge aclk) cycCnt <= cycCnt + 1;

   // Master-side monitor: every visible beat (stalled or not) must equal the scoreboard head.
   always @(negedge aclk) begin
      if (aresetn && m_axis_tvalid) begin
         if (mExp.size() == 0) checkVal("m_unexpected_beat", m_axis_tvalid, 0);
         else begin
            mHead = mExp[0];
            checkVal("m_tdata", m_axis_tdata, {8'h00, mHead[7:0]});
            checkVal("m_tlast", m_axis_tlast, mHead[8]);
            if (m_axis_tready) begin
               void'(mExp.pop_front());
               $display("m beat data %0d last %0d", m_axis_tdata[7:0], m_axis_tlast);
            end
         end
      end
   end

   always @(negedge aclk) begin
      if (err_tlast) errPulses++;
      if (frame_done) fdCount++;
      if (freq_valid) begin
         if (fExp.size() == 0) checkVal("f_unexpected", freq_valid, 0);
         else begin
            fHead = fExp.pop_front();
            checkVal("f_addr", freq_addr, fHead[15:8]);
            checkVal("f_data", freq_data, fHead[7:0]);
            checkVal("f_latency", cycCnt - acceptCyc[freq_addr], 2);
            $display("bin %0d power %0d", freq_addr, freq_data);
         end
      end
   end

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic doReset;
      aresetn = 1'b0;
      repeat (3) tick();
      mExp.delete();
      fExp.delete();
      avgFirstM = 1'b1;
      aresetn = 1'b1;
      tick();
   endtask

   task automatic startFrame;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic sendSamples(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         smp_valid = 1'b1;
         smp_data  = 8'(smpArr[i]);
         tick();
      end
      smp_valid = 1'b0;
   endtask

   task automatic pushFrame(input int first);
      for (int i = 0; i < N; i++) mExp.push_back({(i == N-1), 8'(smpArr[first+i])});
   endtask

   task automatic waitMDrain;
      int t = 0;
      while ((mExp.size() != 0 || m_axis_tvalid) && t < 300) begin
         tick();
         t++;
      end
      if (t >= 300) checkVal("load_timeout", mExp.size(), 0);
   endtask

   task automatic setBeats(input int pat);
      for (int i = 0; i < N; i++) begin
         case (pat)
            0: begin beatRe[i] = i * 700; beatIm[i] = -(i * 300); end
            1: begin beatRe[i] = i * 16000 - 120000; beatIm[i] = 5000 * i; end
            default: begin beatRe[i] = 0; beatIm[i] = 0; end
         endcase
      end
      if (pat == 0) begin
         beatRe[3] = 1000;   beatIm[3] = 0;
         beatRe[7] = 262143; beatIm[7] = 0;
      end
   endtask

   // Acts as the FFT core: returns nBeats bins, tlast at tlastAt, expectations pushed as it goes.
   task automatic replyFrame(input int tlastAt, input int nBeats);
      int t = 0;
      longint r, m, p, v, o;
      while (!s_axis_tready && t < 300) begin
         tick();
         t++;
      end
      if (t >= 300) checkVal("s_ready_timeout", s_axis_tready, 1);
      if (!avg_en) avgFirstM = 1'b1;
      for (int i = 0; i < nBeats; i++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = {laneEnc(beatIm[i], 5'h0B), laneEnc(beatRe[i], 5'h15)};
         s_axis_tlast  = (i == tlastAt);
         r = beatRe[i];
         m = beatIm[i];
         p = r * r + m * m;
         v = p >> (23 - int'(gain));
         if (v > 255) v = 255;
         o = (avg_en && !avgFirstM) ? ((avgM[i] + v + 1) >> 1) : v;
         avgM[i] = int'(o);
         fExp.push_back({8'(i), 8'(o)});
         acceptCyc[i] = cycCnt;
         tick();
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      if (avg_en) avgFirstM = 1'b0;
   endtask

   task automatic waitFrameDone(input int target);
      int t = 0;
      while (fdCount < target && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) checkVal("frame_done_timeout", fdCount, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t;
      repeat (2) tick();
      checkVal("rst_busy", busy, 0);
      checkVal("rst_m_tvalid", m_axis_tvalid, 0);
      checkVal("rst_m_tdata", m_axis_tdata, 0);
      checkVal("rst_s_tready", s_axis_tready, 0);
      checkVal("rst_freq_valid", freq_valid, 0);
      checkVal("rst_frame_done", frame_done, 0);
      checkVal("rst_err_tlast", err_tlast, 0);
      doReset();

      // Free-run ramp, gain 7 scaling with junk above the significant lane bits.
      trig_mode = 2'd0; gain = 3'd7; avg_en = 1'b0; cont = 1'b0; m_axis_tready = 1'b1;
      startFrame();
      for (int i = 0; i < N; i++) smpArr[i] = i;
      pushFrame(0);
      sendSamples(N);
      t = 0;
      @(negedge aclk);
      while (!m_axis_tvalid && t < 20) begin
         @(negedge aclk);
         t++;
      end
      for (int k = 0; k < N; k++) begin
         checkVal("m_no_gap", m_axis_tvalid, 1);
         @(negedge aclk);
      end
      checkVal("m_after_last", m_axis_tvalid, 0);
      #1;
      setBeats(0);
      replyFrame(N-1, N);
      waitFrameDone(1);
      tick();
      checkVal("idle_after_frame", busy, 0);
      checkVal("no_err_clean_frame", errPulses, 0);

      // Rising crossing at level 1; the first sample 2 must only prime prev.
      trig_mode = 2'd1; trig_level = 8'd1; gain = 3'd2; m_axis_tready = 1'b0;
      startFrame();
      smpArr[0] = 2; smpArr[1] = -3; smpArr[2] = -1;
      for (int i = 0; i < N; i++) smpArr[3+i] = 2 + 3 * i;
      pushFrame(3);
      sendSamples(N + 3);
      t = 0;
      while (mExp.size() != 0 && t < 200) begin
         m_axis_tready = ~m_axis_tready;
         tick();
         t++;
      end
      if (t >= 200) checkVal("bp_timeout", mExp.size(), 0);
      m_axis_tready = 1'b1;
      setBeats(1);
      replyFrame(N-1, N);
      waitFrameDone(2);

      // A falling sequence never satisfies a rising trigger.
      startFrame();
      for (int i = 0; i < N; i++) smpArr[i] = 10 - 2 * i;
      sendSamples(N);
      repeat (4) tick();
      checkVal("no_trig_busy", busy, 1);
      checkVal("no_trig_tvalid", m_axis_tvalid, 0);
      doReset();
      checkVal("reset_from_arm_busy", busy, 0);

      // Two-frame averaging on bin 3: 100 then 50.
      trig_mode = 2'd0; gain = 3'd7; avg_en = 1'b1;
      for (int f = 0; f < 2; f++) begin
         startFrame();
         for (int i = 0; i < N; i++) smpArr[i] = 2 * i + f;
         pushFrame(0);
         sendSamples(N);
         waitMDrain();
         setBeats(2);
         beatRe[3] = (f == 0) ? 2560 : 1810;
         beatIm[3] = (f == 0) ? 0 : 27;
         replyFrame(N-1, N);
         waitFrameDone(3 + f);
      end
      avg_en = 1'b0;

      // Early tlast on bin 5 with cont=1, captured on a falling crossing.
      cont = 1'b1; trig_mode = 2'd2; trig_level = 8'd5;
      startFrame();
      smpArr[0] = 9; smpArr[1] = 7;
      for (int i = 0; i < N; i++) smpArr[2+i] = 4 - i;
      pushFrame(2);
      sendSamples(N + 2);
      waitMDrain();
      setBeats(0);
      replyFrame(5, 6);
      waitFrameDone(5);
      checkVal("err_early_tlast", errPulses, 1);
      checkVal("rearm_busy", busy, 1);
      checkVal("rearm_s_tready", s_axis_tready, 0);
      checkVal("rearm_m_tvalid", m_axis_tvalid, 0);

      // Missing tlast on the final bin, then back to IDLE.
      cont = 1'b0; trig_mode = 2'd0;
      for (int i = 0; i < N; i++) smpArr[i] = 100 - i;
      pushFrame(0);
      sendSamples(N);
      waitMDrain();
      setBeats(1);
      replyFrame(-1, N);
      waitFrameDone(6);
      tick();
      checkVal("err_missing_tlast", errPulses, 2);
      checkVal("idle_after_err", busy, 0);

      // Reset while LOAD is stalled.
      m_axis_tready = 1'b0;
      startFrame();
      for (int i = 0; i < N; i++) smpArr[i] = i;
      pushFrame(0);
      sendSamples(N);
      repeat (3) tick();
      checkVal("midload_tvalid", m_axis_tvalid, 1);
      aresetn = 1'b0;
      tick();
      checkVal("midload_rst_busy", busy, 0);
      checkVal("midload_rst_tvalid", m_axis_tvalid, 0);
      checkVal("midload_rst_s_tready", s_axis_tready, 0);
      mExp.delete();
      repeat (2) tick();
      aresetn = 1'b1;
      m_axis_tready = 1'b1;
      repeat (4) tick();
      checkVal("post_rst_busy", busy, 0);
      checkVal("post_rst_freq_valid", freq_valid, 0);

      checkVal("m_queue_empty", mExp.size(), 0);
      checkVal("f_queue_empty", fExp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
